// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// functs, ALU operation and next-PC select codes, and the instruction classes.
package mips_ctrl_pkg;

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic [3:0] {
    IC_NOP, IC_R_ALU, IC_I_ALU, IC_LW, IC_SW, IC_BR, IC_J, IC_JAL, IC_JR, IC_HALT
  } ic_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct decode into instruction class and ALU configuration.
// Unrecognised opcodes and R-type functs decode as nop.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ic_e        cls_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       ext_sel_o,
  output logic       is_rtype_o
);

  always_comb begin
    cls_o       = IC_NOP;
    alu_op_o    = ALU_ADD;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    ext_sel_o   = 1'b0;
    is_rtype_o  = (op_i == OP_RTYPE);
    if (op_i == HALT_OP) begin
      cls_o = IC_HALT;
    end else begin
      case (op_i)
        OP_RTYPE: begin
          case (funct_i)
            F_ADD: begin cls_o = IC_R_ALU; alu_op_o = ALU_ADD; end
            F_SUB: begin cls_o = IC_R_ALU; alu_op_o = ALU_SUB; end
            F_AND: begin cls_o = IC_R_ALU; alu_op_o = ALU_AND; end
            F_OR:  begin cls_o = IC_R_ALU; alu_op_o = ALU_OR;  end
            F_SLT: begin cls_o = IC_R_ALU; alu_op_o = ALU_SLT; end
            F_SLL: begin cls_o = IC_R_ALU; alu_op_o = ALU_SLL; alu_src_a_o = 1'b1; end
            F_JR:  cls_o = IC_JR;
            default: cls_o = IC_NOP;
          endcase
        end
        OP_ADDIU: begin cls_o = IC_I_ALU; alu_op_o = ALU_ADD; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
        OP_SLTI:  begin cls_o = IC_I_ALU; alu_op_o = ALU_SLT; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
        OP_ANDI:  begin cls_o = IC_I_ALU; alu_op_o = ALU_AND; alu_src_b_o = 1'b1; end
        OP_ORI:   begin cls_o = IC_I_ALU; alu_op_o = ALU_OR;  alu_src_b_o = 1'b1; end
        OP_LW:    begin cls_o = IC_LW; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
        OP_SW:    begin cls_o = IC_SW; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
        OP_BEQ, OP_BNE, OP_BLTZ: begin cls_o = IC_BR; alu_op_o = ALU_SUB; ext_sel_o = 1'b1; end
        OP_J:     cls_o = IC_J;
        OP_JAL:   cls_o = IC_JAL;
        default:  cls_o = IC_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and drives all datapath strobes.
// Outputs are combinational; while RST is high they already show IF values so nothing commits.
module mc_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int         ST_W    = 3,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            sign,
  output logic            PCWre,
  output logic [1:0]      PCSrc,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic            RegWre,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [2:0]      ALUOp,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0] state_q, state_d, out_st;
  ic_e             cls;
  logic [2:0]      dec_alu_op;
  logic            dec_src_a, dec_src_b, dec_ext, is_rtype, br_taken;

  mc_ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
    .op_i        (op),
    .funct_i     (funct),
    .cls_o       (cls),
    .alu_op_o    (dec_alu_op),
    .alu_src_a_o (dec_src_a),
    .alu_src_b_o (dec_src_b),
    .ext_sel_o   (dec_ext),
    .is_rtype_o  (is_rtype)
  );

  assign br_taken = ((op == OP_BEQ)  &&  zero) ||
                    ((op == OP_BNE)  && !zero) ||
                    ((op == OP_BLTZ) &&  sign);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls)
          IC_J, IC_JAL, IC_JR, IC_HALT, IC_NOP: state_d = S_IF;
          IC_BR:                                state_d = S_EXE_BR;
          IC_LW, IC_SW:                         state_d = S_EXE_LS;
          default:                              state_d = S_EXE_AL;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (cls == IC_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Reset overrides the decoded state so a write in flight is never strobed.
  assign out_st = RST ? S_IF : state_q;
  assign state  = state_q;

  always_comb begin
    PCWre = 1'b0; PCSrc = PC_SEQ; IRWre = 1'b0; InsMemRW = 1'b0;
    RegWre = 1'b0; RegDst = 2'b00; WrRegDSrc = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB = 1'b0; ExtSel = 1'b0; ALUOp = ALU_ADD; mRD = 1'b0;
    mWR = 1'b0; DBDataSrc = 1'b0;
    case (out_st)
      S_IF: begin IRWre = 1'b1; InsMemRW = 1'b1; end
      S_ID: begin
        case (cls)
          IC_J:   begin PCWre = 1'b1; PCSrc = PC_J; end
          IC_JAL: begin PCWre = 1'b1; PCSrc = PC_J; RegWre = 1'b1; RegDst = 2'b00; end
          IC_JR:  begin PCWre = 1'b1; PCSrc = PC_JR; end
          IC_NOP: begin PCWre = 1'b1; PCSrc = PC_SEQ; end
          default: ;
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        ALUOp = dec_alu_op; ALUSrcA = dec_src_a; ALUSrcB = dec_src_b; ExtSel = dec_ext;
        if (out_st == S_WB_AL) begin
          RegWre = 1'b1; WrRegDSrc = 1'b1; PCWre = 1'b1;
          RegDst = is_rtype ? 2'b10 : 2'b01;
        end
      end
      S_EXE_BR: begin
        ALUOp = ALU_SUB; ExtSel = 1'b1; PCWre = 1'b1;
        PCSrc = br_taken ? PC_BR : PC_SEQ;
      end
      S_EXE_LS, S_MEM: begin
        ALUOp = ALU_ADD; ALUSrcB = 1'b1; ExtSel = 1'b1;
        if (out_st == S_MEM) begin
          if (cls == IC_SW) begin mWR = 1'b1; PCWre = 1'b1; end
          else              mRD = 1'b1;
        end
      end
      S_WB_LD: begin
        RegWre = 1'b1; RegDst = 2'b01; WrRegDSrc = 1'b1; DBDataSrc = 1'b1; PCWre = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-feature tasks with hand-computed expectations.
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] op, funct;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  int n_cmp  = 0;
  int n_fail = 0;

  mc_control_unit dut (
    .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0; sign = 1'b0;
    step(); step();
    n_cmp++;
    if ({state, IRWre, InsMemRW, PCWre, RegWre, mWR} !== {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: state=%b IRWre=%b InsMemRW=%b PCWre=%b RegWre=%b mWR=%b, want 000 1 1 0 0 0",
               state, IRWre, InsMemRW, PCWre, RegWre, mWR);
    end
    RST = 1'b0;
  endtask

  task automatic test_lw();
    logic [2:0] seq [5];
    seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({state, PCWre} !== {seq[i], (seq[i] == 3'b100)}) begin
        n_fail++;
        $display("FAIL lw_seq[%0d]: state=%b PCWre=%b, want %b %b", i, state, PCWre, seq[i], seq[i] == 3'b100);
      end
      if (seq[i] == 3'b011) begin
        n_cmp++;
        if ({mRD, mWR} !== 2'b10) begin
          n_fail++; $display("FAIL lw_mem: mRD/mWR=%b, want 10", {mRD, mWR});
        end
      end
      if (seq[i] == 3'b100) begin
        n_cmp++;
        if ({RegWre, DBDataSrc, RegDst, PCSrc} !== {1'b1, 1'b1, 2'b01, 2'b00}) begin
          n_fail++;
          $display("FAIL lw_wb: RegWre=%b DBDataSrc=%b RegDst=%b PCSrc=%b, want 1 1 01 00",
                   RegWre, DBDataSrc, RegDst, PCSrc);
        end
      end
    end
  endtask

  task automatic test_alu();
    // add: IF->ID->EXE_AL->WB_AL->IF is 4 cycles
    op = 6'b000000; funct = 6'b100000;
    step(); step();
    n_cmp++;
    if ({state, ALUOp, ALUSrcA, ALUSrcB, PCWre} !== {3'b110, 3'b000, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_exe: state=%b ALUOp=%b A=%b B=%b PCWre=%b, want 110 000 0 0 0",
                         state, ALUOp, ALUSrcA, ALUSrcB, PCWre);
    end
    step();
    n_cmp++;
    if ({state, RegWre, RegDst, PCWre, PCSrc, DBDataSrc, mWR} !== {3'b111, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_wb: state=%b RegWre=%b RegDst=%b PCWre=%b PCSrc=%b DBDataSrc=%b mWR=%b",
                         state, RegWre, RegDst, PCWre, PCSrc, DBDataSrc, mWR);
    end
    step();
    n_cmp++;
    if (state !== 3'b000) begin
      n_fail++; $display("FAIL add_len: state=%b, want 000 after 4 cycles", state);
    end
    // ori: zero-extended immediate, RegDst=rt
    op = 6'b001101;
    step(); step();
    n_cmp++;
    if ({state, ALUOp, ALUSrcB, ExtSel} !== {3'b110, 3'b011, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ori_exe: state=%b ALUOp=%b B=%b Ext=%b, want 110 011 1 0", state, ALUOp, ALUSrcB, ExtSel);
    end
    step();
    n_cmp++;
    if ({RegWre, RegDst} !== {1'b1, 2'b01}) begin
      n_fail++; $display("FAIL ori_wb: RegWre=%b RegDst=%b, want 1 01", RegWre, RegDst);
    end
    step();
    // sll: shamt source
    op = 6'b000000; funct = 6'b000000;
    step(); step();
    n_cmp++;
    if ({state, ALUOp, ALUSrcA, ALUSrcB} !== {3'b110, 3'b010, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sll_exe: state=%b ALUOp=%b A=%b B=%b, want 110 010 1 0", state, ALUOp, ALUSrcA, ALUSrcB);
    end
    step(); step();
    // slti: signed immediate compare
    op = 6'b001010;
    step(); step();
    n_cmp++;
    if ({ALUOp, ALUSrcB, ExtSel} !== {3'b101, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL slti_exe: ALUOp=%b B=%b Ext=%b, want 101 1 1", ALUOp, ALUSrcB, ExtSel);
    end
    step(); step();
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs  [4][2];
    logic [1:0] exp [4];
    ops = '{6'b000100, 6'b000100, 6'b000001, 6'b000101};
    zs  = '{'{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b0}};
    exp = '{2'b01, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      op = ops[i]; zero = zs[i][0]; sign = zs[i][1];
      step();
      n_cmp++;
      if ({state, PCWre} !== {3'b001, 1'b0}) begin
        n_fail++; $display("FAIL br_id[%0d]: state=%b PCWre=%b, want 001 0", i, state, PCWre);
      end
      step();
      n_cmp++;
      if ({state, PCWre, PCSrc, ALUOp, ExtSel} !== {3'b101, 1'b1, exp[i], 3'b001, 1'b1}) begin
        n_fail++; $display("FAIL br_exe[%0d]: state=%b PCWre=%b PCSrc=%b ALUOp=%b Ext=%b, want 101 1 %b 001 1",
                           i, state, PCWre, PCSrc, ALUOp, ExtSel, exp[i]);
      end
      step();
      n_cmp++;
      if (state !== 3'b000) begin
        n_fail++; $display("FAIL br_len[%0d]: state=%b, want 000", i, state);
      end
    end
    zero = 1'b0; sign = 1'b0;
  endtask

  task automatic test_jump();
    // jal
    op = 6'b000011;
    step();
    n_cmp++;
    if ({state, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc} !== {3'b001, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL jal_id: state=%b PCWre=%b PCSrc=%b RegWre=%b RegDst=%b WrRegDSrc=%b, want 001 1 11 1 00 0",
                         state, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc);
    end
    step();
    n_cmp++;
    if (state !== 3'b000) begin
      n_fail++; $display("FAIL jal_len: state=%b, want 000", state);
    end
    // jr
    op = 6'b000000; funct = 6'b001000;
    step();
    n_cmp++;
    if ({PCWre, PCSrc, RegWre} !== {1'b1, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL jr_id: PCWre=%b PCSrc=%b RegWre=%b, want 1 10 0", PCWre, PCSrc, RegWre);
    end
    step();
    // j
    op = 6'b000010;
    step();
    n_cmp++;
    if ({PCWre, PCSrc, RegWre} !== {1'b1, 2'b11, 1'b0}) begin
      n_fail++; $display("FAIL j_id: PCWre=%b PCSrc=%b RegWre=%b, want 1 11 0", PCWre, PCSrc, RegWre);
    end
    step();
    // unknown opcode: nop
    op = 6'b111000;
    step();
    n_cmp++;
    if ({state, PCWre, PCSrc, RegWre} !== {3'b001, 1'b1, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL nop_id: state=%b PCWre=%b PCSrc=%b RegWre=%b, want 001 1 00 0", state, PCWre, PCSrc, RegWre);
    end
    step();
    n_cmp++;
    if (state !== 3'b000) begin
      n_fail++; $display("FAIL nop_len: state=%b, want 000", state);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    op = 6'b111111;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state !== ((i % 2 == 0) ? 3'b001 : 3'b000) || PCWre !== 1'b0 || RegWre !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halt_spin: %0d of 20 cycles off the 001/000 pattern or with PCWre/RegWre set, want 0", bad);
    end
    RST = 1'b1;
    step();
    n_cmp++;
    if ({state, PCWre} !== {3'b000, 1'b0}) begin
      n_fail++; $display("FAIL halt_rst: state=%b PCWre=%b, want 000 0", state, PCWre);
    end
    RST = 1'b0;
  endtask

  task automatic test_sw_reset();
    op = 6'b101011;
    step(); step(); step();
    n_cmp++;
    if ({state, mWR, PCWre} !== {3'b011, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sw_mem: state=%b mWR=%b PCWre=%b, want 011 1 1", state, mWR, PCWre);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({mWR, RegWre, PCWre, IRWre} !== 4'b0001) begin
      n_fail++; $display("FAIL sw_rst_cycle: mWR=%b RegWre=%b PCWre=%b IRWre=%b, want 0 0 0 1", mWR, RegWre, PCWre, IRWre);
    end
    step();
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({state, mWR} !== {3'b000, 1'b0}) begin
      n_fail++; $display("FAIL sw_rst_next: state=%b mWR=%b, want 000 0", state, mWR);
    end
    step();
    n_cmp++;
    if ({state, mWR} !== {3'b001, 1'b0}) begin
      n_fail++; $display("FAIL sw_refetch: state=%b mWR=%b, want 001 0", state, mWR);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_branch();
    test_jump();
    test_halt();
    test_sw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control FSM for the MIPS core. It sequences each instruction through the fetch, decode, execute, memory and write-back states. It is the driving end of the PC write interface: it produces PCWre and PCSrc[1:0] for the PC register and next-address selector, plus every other datapath strobe. Inputs are the opcode/funct from the instruction register and the ALU flags.

Parameters:
ST_W, 3, state register width
HALT_OP, 6'b111111, opcode that freezes the PC

Ports:
CLK  input  1  clock, all state changes on rising edge
RST  input  1  synchronous reset, active-high; forces state IF on next rising edge
op  input  6  IR[31:26]
funct  input  6  IR[5:0], used only when op==6'b000000
zero  input  1  ALU result==0
sign  input  1  ALU result[31]
PCWre  output  1  PC write enable, one cycle per instruction
PCSrc  output  2  00 PC+4, 01 branch, 10 jr (rs), 11 j/jal
IRWre  output  1  IR load enable
InsMemRW  output  1  instruction memory read
RegWre  output  1  register file write enable
RegDst  output  2  00 $31, 01 rt, 10 rd
WrRegDSrc  output  1  0 PC+4 (jal), 1 DB data
ALUSrcA  output  1  1 selects shamt (sll)
ALUSrcB  output  1  1 selects extended immediate
ExtSel  output  1  1 sign-extend, 0 zero-extend
ALUOp  output  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed slt
mRD  output  1  data memory read
mWR  output  1  data memory write
DBDataSrc  output  1  1 memory data, 0 ALU result
state  output  3  current state, for debug

Behaviour:
- States: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
- Outputs are combinational from state, op, funct, zero and sign. The IR is stable from ID onward.
- Reset: state=IF. All outputs then take their IF values: IRWre=1, InsMemRW=1, all other outputs 0.
- RST has priority over every transition, including a transition mid-instruction. No partial write may be committed in the reset cycle: the outputs already show IF values, so RegWre, mWR and PCWre are 0.
- IF: IRWre=1, InsMemRW=1 -> ID.
- ID transitions:
  - j: PCWre=1, PCSrc=11 -> IF.
  - jal: additionally RegWre=1, RegDst=00, WrRegDSrc=0 -> IF.
  - jr (op 0, funct 001000): PCWre=1, PCSrc=10 -> IF.
  - halt: PCWre=0 -> IF. The same PC is refetched, so the core spins until reset.
  - Unknown opcode: nop; PCWre=1, PCSrc=00 -> IF.
  - beq, bne, bltz -> EXE_BR.
  - lw, sw -> EXE_LS.
  - All other instructions -> EXE_AL.
- EXE_AL: ALU configured per instruction -> WB_AL.
  - R-type add/sub/and/or/slt/sll: ALUSrcB=0.
  - sll: ALUSrcA=1.
  - addiu, slti: ExtSel=1.
  - andi, ori: ExtSel=0.
  - Immediate forms: ALUSrcB=1.
- WB_AL: RegWre=1, DBDataSrc=0, RegDst=10 for R-type, 01 otherwise; PCWre=1, PCSrc=00 -> IF.
- EXE_BR: ALUOp=001 (sub), ExtSel=1, PCWre=1 -> IF.
  - Taken (beq & zero, bne & !zero, bltz & sign): PCSrc=01.
  - Not taken: PCSrc=00.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1 -> MEM.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00 -> IF.
  - lw: mRD=1 -> WB_LD.
- WB_LD: RegWre=1, RegDst=01, DBDataSrc=1, PCWre=1, PCSrc=00 -> IF.
- Invariants:
  - PCWre is asserted in exactly one state per instruction, the last one, and never in IF.
  - PCSrc is don't-care (driven 00) whenever PCWre=0.
  - mWR and RegWre are never high in the same cycle.
- Latency in cycles, IF to next IF: j/jal/jr/halt 2; beq/bne/bltz 3; sw 4; R-type/imm ALU 4; lw 5.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - opcode/funct constants (add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000; addiu 001001, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, bltz 000001, j 000010, jal 000011, halt 111111)
  - ALUOp and PCSrc codes
- One sub-module, mc_ctrl_decode: purely combinational op/funct -> instruction-class and ALU-config decode. The FSM and output gating stay in mc_control_unit.

Test Plan:
- RST=1 for 2 cycles with op=100011 -> state=000, IRWre=1, PCWre=0. Release -> state sequence 001,010,011,100,000; PCWre=1 only in state 100, with RegWre=1 and DBDataSrc=1.
- op=000000, funct=100000 (add) -> sequence 001,110,111; in 111: RegWre=1, RegDst=10, PCWre=1, PCSrc=00; 4 cycles total.
- beq with zero=1 -> in 101: PCWre=1, PCSrc=01, ALUOp=001. Repeat with zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- jal -> in 001: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state 000. jr -> PCSrc=10 in 001.
- op=111111 held for 20 cycles -> state alternates 000/001, PCWre stays 0 throughout; RST=1 -> state 000.
- sw with RST=1 asserted while in state 011 -> next state 000, no cycle with mWR=1 follows. In the reset cycle itself, mWR, RegWre and PCWre are 0.
